// File: rtl/lv_hv_owt_pkg.sv
// Shared LV/HV one-wire transport definitions: response status codes,
// HV responder FSM states and the HV register address range.
package lv_hv_owt_pkg;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        ADDR_ERR = 2'b10,
        TMO      = 2'b11
    } owt_rsp_status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RSP  = 2'd2
    } owt_rsp_state_e;

    // Reused on the LV side for HV_ANALOG range checks
    localparam logic [6:0] HV_REG_ADDR_MAX = 7'h1F;

endpackage

// File: rtl/hv_owt_reg_responder.sv
// HV-side OWT register-access responder: runs one decoded request frame
// against the HV register bank and returns a write echo or read data.
module hv_owt_reg_responder
    import lv_hv_owt_pkg::*;
#(
    parameter int unsigned        REG_AW          = 7,
    parameter int unsigned        REG_DW          = 8,
    parameter logic [REG_AW-1:0]  HV_REG_ADDR_MAX = lv_hv_owt_pkg::HV_REG_ADDR_MAX,
    parameter int unsigned        REG_TMO_CYC     = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_owt_rx_vld,
    input  logic              i_owt_rx_wr,
    input  logic [REG_AW-1:0] i_owt_rx_addr,
    input  logic [REG_DW-1:0] i_owt_rx_data,
    input  logic              i_owt_rx_crc_err,
    output logic              o_hrc_reg_wen,
    output logic              o_hrc_reg_ren,
    output logic [REG_AW-1:0] o_hrc_reg_addr,
    output logic [REG_DW-1:0] o_hrc_reg_wdata,
    input  logic              i_reg_hrc_wack,
    input  logic              i_reg_hrc_rack,
    input  logic [REG_DW-1:0] i_reg_hrc_rdata,
    output logic              o_owt_tx_req,
    output logic              o_owt_tx_wr,
    output logic [REG_AW-1:0] o_owt_tx_addr,
    output logic [REG_DW-1:0] o_owt_tx_data,
    output logic [1:0]        o_owt_tx_status,
    input  logic              i_owt_tx_ack,
    output logic              o_busy,
    output logic              o_rx_drop,
    output logic              o_tmo_err
);

    localparam int unsigned TW = $clog2(REG_TMO_CYC + 1);

    owt_rsp_state_e    r_state;
    owt_rsp_status_e   r_tx_status;
    logic              r_wr;
    logic              r_wen;
    logic              r_ren;
    logic [REG_AW-1:0] r_hrc_addr;
    logic [REG_DW-1:0] r_hrc_wdata;
    logic              r_tx_req;
    logic              r_tx_wr;
    logic [REG_AW-1:0] r_tx_addr;
    logic [REG_DW-1:0] r_tx_data;
    logic              r_busy;
    logic              r_rx_drop;
    logic              r_tmo_err;
    logic [TW-1:0]     r_tmr;

    logic              w_ack;
    logic [TW-1:0]     w_tmr_nxt;
    logic              w_tmo;

    // Only the ack matching the latched request type completes the access
    assign w_ack     = r_wr ? i_reg_hrc_wack : i_reg_hrc_rack;
    assign w_tmr_nxt = r_tmr + 1'b1;
    assign w_tmo     = (w_tmr_nxt == TW'(REG_TMO_CYC));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_tx_status <= OK;
            r_wr        <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_hrc_addr  <= '0;
            r_hrc_wdata <= '0;
            r_tx_req    <= 1'b0;
            r_tx_wr     <= 1'b0;
            r_tx_addr   <= '0;
            r_tx_data   <= '0;
            r_busy      <= 1'b0;
            r_rx_drop   <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_tmr       <= '0;
        end else begin
            r_rx_drop <= 1'b0;
            r_tmo_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_owt_rx_vld) begin
                        if (i_owt_rx_crc_err) begin
                            r_rx_drop <= 1'b1;
                        end else if (i_owt_rx_addr > HV_REG_ADDR_MAX) begin
                            r_wr        <= i_owt_rx_wr;
                            r_tx_wr     <= i_owt_rx_wr;
                            r_tx_addr   <= i_owt_rx_addr;
                            r_tx_data   <= '0;
                            r_tx_status <= ADDR_ERR;
                            r_tx_req    <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_RSP;
                        end else begin
                            r_wr        <= i_owt_rx_wr;
                            r_hrc_addr  <= i_owt_rx_addr;
                            r_hrc_wdata <= i_owt_rx_data;
                            r_wen       <= i_owt_rx_wr;
                            r_ren       <= ~i_owt_rx_wr;
                            r_tmr       <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (i_owt_rx_vld) r_rx_drop <= 1'b1;
                    // Ack is checked first so it wins over a same-cycle expiry
                    if (w_ack || w_tmo) begin
                        r_wen     <= 1'b0;
                        r_ren     <= 1'b0;
                        r_tmr     <= '0;
                        r_tx_wr   <= r_wr;
                        r_tx_addr <= r_hrc_addr;
                        r_tx_req  <= 1'b1;
                        r_state   <= ST_RSP;
                        if (w_ack) begin
                            r_tx_data   <= r_wr ? r_hrc_wdata : i_reg_hrc_rdata;
                            r_tx_status <= OK;
                        end else begin
                            r_tx_data   <= '0;
                            r_tx_status <= TMO;
                            r_tmo_err   <= 1'b1;
                        end
                    end else begin
                        r_tmr <= w_tmr_nxt;
                    end
                end
                ST_RSP: begin
                    if (i_owt_rx_vld) r_rx_drop <= 1'b1;
                    if (i_owt_tx_ack) begin
                        r_tx_req <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_wen    <= 1'b0;
                    r_ren    <= 1'b0;
                    r_tx_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_hrc_reg_wen   = r_wen;
    assign o_hrc_reg_ren   = r_ren;
    assign o_hrc_reg_addr  = r_hrc_addr;
    assign o_hrc_reg_wdata = r_hrc_wdata;
    assign o_owt_tx_req    = r_tx_req;
    assign o_owt_tx_wr     = r_tx_wr;
    assign o_owt_tx_addr   = r_tx_addr;
    assign o_owt_tx_data   = r_tx_data;
    assign o_owt_tx_status = r_tx_status;
    assign o_busy          = r_busy;
    assign o_rx_drop       = r_rx_drop;
    assign o_tmo_err       = r_tmo_err;

endmodule
